// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan-chain load controller.
//   IDLE / SHIFT / UPDATE : 2-bit state encodings
//   state_e               : FSM state type built on those encodings
// No ports (package).
// -----------------------------------------------------------------------------
package scan_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SHIFT  = SHIFT,
    ST_UPDATE = UPDATE
  } state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// -----------------------------------------------------------------------------
// scan_shift_reg
// WIDTH-bit shift register with parallel load and serial input at the MSB.
// Parallel load has priority over shifting. It shifts right, one bit per enabled cycle.
// Ports:
//   i_clk       : rising-edge clock
//   i_rst_n     : synchronous active-low reset, clears the register
//   i_load      : load i_data in parallel
//   i_data      : parallel word
//   i_shift     : shift right by one, i_serial_in enters at the MSB
//   i_serial_in : serial fill bit
//   o_q         : current register contents
// -----------------------------------------------------------------------------
module scan_shift_reg #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_r;

  // Shift register storage: reset, parallel load, or right shift
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (i_load) begin
      q_r <= i_data;
    end else if (i_shift) begin
      q_r <= {i_serial_in, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign o_q = q_r;

endmodule

// File: rtl/scan_load_ctrl.sv
// -----------------------------------------------------------------------------
// scan_load_ctrl
// Accepts a parallel word through a valid/ready handshake. It shifts the word
// LSB first into an external scan chain, then pulses o_update for one cycle so
// the chain's shadow register bank loads. All outputs come from registers.
//
// Optional build macro: SCAN_LOAD_CTRL_READBACK_EN
//   defined   : bits returned on i_scan_in fill the shift register MSB, and the
//               previous chain contents appear on o_rd_data with an o_rd_valid
//               pulse in the o_update cycle
//   undefined : o_rd_data/o_rd_valid are held at 0, i_scan_in is ignored, and
//               the MSB fill is 0
//
// Ports:
//   i_clk      : rising-edge clock
//   i_rst_n    : synchronous active-low reset
//   i_valid    : load request present
//   o_ready    : controller can accept a request
//   i_data     : parallel word to scan in (WIDTH bits)
//   o_scan_en  : chain shift enable
//   o_scan_out : serial data to the chain head
//   i_scan_in  : serial return from the chain tail
//   o_update   : one-cycle shadow register load strobe
//   o_busy     : high whenever the controller is not idle
//   o_rd_data  : captured previous chain contents (WIDTH bits)
//   o_rd_valid : o_rd_data updated this cycle
// -----------------------------------------------------------------------------
module scan_load_ctrl
  import scan_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_scan_en,
  output logic             o_scan_out,
  input  logic             i_scan_in,
  output logic             o_update,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_r;
  state_e           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic             load_s;
  logic             shift_s;
  logic             fill_s;
  logic [WIDTH-1:0] shreg_s;
  logic             unused_s;

  logic             ready_r;
  logic             ready_s;
  logic             scan_en_r;
  logic             scan_en_s;
  logic             scan_out_r;
  logic             scan_out_s;
  logic             update_r;
  logic             update_s;
  logic             busy_r;
  logic             busy_s;

  scan_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (load_s),
    .i_data      (i_data),
    .i_shift     (shift_s),
    .i_serial_in (fill_s),
    .o_q         (shreg_s)
  );

  // Next-state, counter and shift-register control
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Handshake uses the registered ready, which is low in the cycle
        // right after reset, so a request held across reset waits a cycle.
        if (i_valid && ready_r) begin
          load_s  = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        cnt_s   = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_UPDATE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so that
  // every output can be registered without adding a cycle of latency
  always_comb begin
    ready_s   = (state_s == ST_IDLE);
    scan_en_s = (state_s == ST_SHIFT);
    update_s  = (state_s == ST_UPDATE);
    busy_s    = (state_s != ST_IDLE);
    // The head bit next cycle is the LSB of what the register will hold:
    // i_data[0] on load, or bit 1 of the current contents after a shift.
    if (load_s) begin
      scan_out_s = i_data[0];
    end else if (shift_s && (state_s == ST_SHIFT)) begin
      scan_out_s = shreg_s[1];
    end else begin
      scan_out_s = 1'b0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      ready_r    <= 1'b0;
      scan_en_r  <= 1'b0;
      scan_out_r <= 1'b0;
      update_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      ready_r    <= ready_s;
      scan_en_r  <= scan_en_s;
      scan_out_r <= scan_out_s;
      update_r   <= update_s;
      busy_r     <= busy_s;
    end
  end

`ifdef SCAN_LOAD_CTRL_READBACK_EN
  logic [WIDTH-1:0] shift_next_s;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_valid_r;
  logic             rd_valid_s;

  assign fill_s = i_scan_in;
  // Bit 0 leaves the register on the final shift and is never read back.
  assign unused_s = shreg_s[0];

  // Value the shift register takes on the final shift, captured directly so
  // the readback appears in the same cycle as the update strobe
  always_comb begin
    shift_next_s = {fill_s, shreg_s[WIDTH-1:1]};
    if (state_s == ST_UPDATE) begin
      rd_valid_s = 1'b1;
    end else begin
      rd_valid_s = 1'b0;
    end
  end

  // Readback capture register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_data_r  <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_valid_s) begin
      rd_data_r  <= shift_next_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

  assign o_rd_data  = rd_data_r;
  assign o_rd_valid = rd_valid_r;
`else
  assign fill_s     = 1'b0;
  assign unused_s   = ^{i_scan_in, shreg_s};
  assign o_rd_data  = {WIDTH{1'b0}};
  assign o_rd_valid = 1'b0;
`endif

  assign o_ready    = ready_r;
  assign o_scan_en  = scan_en_r;
  assign o_scan_out = scan_out_r;
  assign o_update   = update_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_scan_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_load_ctrl
// Self-checking bench for scan_load_ctrl with WIDTH=10. The external scan chain
// is a 10-bit register. It shifts whenever o_scan_en is high and drives
// i_scan_in from its tail. Expected values come from the cycle-numbered load
// timeline:
//   cycle 0       accept
//   cycles 1..W   shift enabled, head bit = data bit k-1
//   cycle W+1     update strobe
//   cycle W+2     ready again
// The readback value is the chain contents captured at accept time.
// -----------------------------------------------------------------------------
module tb_scan_load_ctrl;

  localparam int W = 10;
`ifdef SCAN_LOAD_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         i_clk   = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_data  = '0;
  logic         i_scan_in;
  logic         o_ready;
  logic         o_scan_en;
  logic         o_scan_out;
  logic         o_update;
  logic         o_busy;
  logic [W-1:0] o_rd_data;
  logic         o_rd_valid;

  logic [W-1:0] chain = '0;
  int passed = 0;
  int total  = 0;

  scan_load_ctrl #(.WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_scan_en  (o_scan_en),
    .o_scan_out (o_scan_out),
    .i_scan_in  (i_scan_in),
    .o_update   (o_update),
    .o_busy     (o_busy),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid)
  );

  always #5 i_clk = ~i_clk;

  // External scan chain: head fed by o_scan_out, tail returns on i_scan_in
  always @(posedge i_clk) begin
    if (o_scan_en) chain <= {o_scan_out, chain[W-1:1]};
  end
  assign i_scan_in = chain[0];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (o_ready !== 1'b1) $display("FAIL wait_ready got %b want 1 within 50 cycles", o_ready);
    else passed++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 10'h3C3;
    repeat (3) step();
    @(negedge i_clk);
    total++; if (o_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", o_ready); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else passed++;
    total++; if (o_scan_en !== 1'b0) $display("FAIL reset_scan_en got %b want 0", o_scan_en); else passed++;
    total++; if (o_scan_out !== 1'b0) $display("FAIL reset_scan_out got %b want 0", o_scan_out); else passed++;
    total++; if (o_update !== 1'b0) $display("FAIL reset_update got %b want 0", o_update); else passed++;
    total++; if (o_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", o_rd_valid); else passed++;
    total++; if (o_rd_data !== 10'h000) $display("FAIL reset_rd_data got %h want 000", o_rd_data); else passed++;
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    step();
    @(negedge i_clk);
    total++; if (o_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", o_ready); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", o_busy); else passed++;
    step();
  endtask

  // One full load with per-cycle checks; glitch_cycle>0 raises a stray
  // request (data 155) during that cycle, which must be ignored.
  task automatic run_load(input logic [W-1:0] data, input int glitch_cycle);
    logic [W-1:0] exp_rd;
    wait_ready();
    exp_rd  = RB ? chain : '0;
    i_data  = data;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_data  = W'($urandom());
    for (int k = 1; k <= W + 2; k++) begin
      if (k == glitch_cycle) begin
        i_valid = 1'b1;
        i_data  = 10'h155;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      total++; if (o_scan_en !== (k <= W)) $display("FAIL load_scan_en c%0d got %b want %b", k, o_scan_en, (k <= W)); else passed++;
      if (k <= W) begin
        total++; if (o_scan_out !== data[k-1]) $display("FAIL load_scan_out c%0d data %h got %b want %b", k, data, o_scan_out, data[k-1]); else passed++;
      end
      total++; if (o_update !== (k == W + 1)) $display("FAIL load_update c%0d got %b want %b", k, o_update, (k == W + 1)); else passed++;
      total++; if (o_busy !== (k <= W + 1)) $display("FAIL load_busy c%0d got %b want %b", k, o_busy, (k <= W + 1)); else passed++;
      total++; if (o_ready !== (k == W + 2)) $display("FAIL load_ready c%0d got %b want %b", k, o_ready, (k == W + 2)); else passed++;
      total++; if (o_rd_valid !== (RB && (k == W + 1))) $display("FAIL load_rd_valid c%0d got %b want %b", k, o_rd_valid, (RB && (k == W + 1))); else passed++;
      if (k == W + 1) begin
        total++; if (o_rd_data !== exp_rd) $display("FAIL load_rd_data got %h want %h", o_rd_data, exp_rd); else passed++;
      end
      step();
    end
    i_valid = 1'b0;
  endtask

  task automatic test_single_loads();
    run_load(10'h2A5, 0);
    repeat (4) run_load(W'($urandom()), 0);
  endtask

  task automatic test_readback();
    run_load(10'h3FF, 0);
    run_load(10'h001, 0);
    @(negedge i_clk);
    total++; if (o_rd_data !== (RB ? 10'h3FF : 10'h000)) $display("FAIL readback_second got %h want %h", o_rd_data, (RB ? 10'h3FF : 10'h000)); else passed++;
    step();
  endtask

  task automatic test_ignore_valid();
    int nupd = 0;
    run_load(W'($urandom()), 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      if (o_update === 1'b1) nupd++;
      total++; if (o_busy !== 1'b0) $display("FAIL ignore_busy +%0d got %b want 0", k, o_busy); else passed++;
      step();
    end
    total++; if (nupd !== 0) $display("FAIL ignore_extra_update got %0d want 0", nupd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    int upd[$];
    a = W'($urandom());
    b = W'($urandom());
    wait_ready();
    exp_a   = RB ? chain : '0;
    exp_b   = RB ? a : '0;
    i_data  = a;
    i_valid = 1'b1;
    step();
    i_data = b;
    for (int c = 1; c <= 26; c++) begin
      if (c == 13) i_valid = 1'b0;
      @(negedge i_clk);
      if (o_update === 1'b1) upd.push_back(c);
      if (c <= W) begin
        total++; if (o_scan_out !== a[c-1]) $display("FAIL b2b_scan_out_a c%0d got %b want %b", c, o_scan_out, a[c-1]); else passed++;
      end
      if (c >= 13 && c <= 22) begin
        total++; if (o_scan_out !== b[c-13]) $display("FAIL b2b_scan_out_b c%0d got %b want %b", c, o_scan_out, b[c-13]); else passed++;
      end
      if (c == 12) begin
        total++; if (o_ready !== 1'b1) $display("FAIL b2b_ready_c12 got %b want 1", o_ready); else passed++;
        total++; if (o_scan_en !== 1'b0) $display("FAIL b2b_scan_en_c12 got %b want 0", o_scan_en); else passed++;
      end
      if (c == 13) begin
        total++; if (o_scan_en !== 1'b1) $display("FAIL b2b_scan_en_c13 got %b want 1", o_scan_en); else passed++;
      end
      if (c == 11) begin
        total++; if (o_rd_data !== exp_a) $display("FAIL b2b_rd_a got %h want %h", o_rd_data, exp_a); else passed++;
      end
      if (c == 23) begin
        total++; if (o_rd_data !== exp_b) $display("FAIL b2b_rd_b got %h want %h", o_rd_data, exp_b); else passed++;
      end
      step();
    end
    total++; if (upd.size() !== 2) $display("FAIL b2b_update_count got %0d want 2", upd.size()); else passed++;
    if (upd.size() >= 2) begin
      total++; if (upd[0] !== 11) $display("FAIL b2b_update_first got %0d want 11", upd[0]); else passed++;
      total++; if (upd[1] !== 23) $display("FAIL b2b_update_second got %0d want 23", upd[1]); else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int nupd = 0;
    int nrdv = 0;
    wait_ready();
    i_data  = W'($urandom());
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) i_rst_n = 1'b0;
      if (c == 6) i_rst_n = 1'b1;
      @(negedge i_clk);
      if (o_update === 1'b1) nupd++;
      if (o_rd_valid === 1'b1) nrdv++;
      if (c <= 5) begin
        total++; if (o_scan_en !== 1'b1) $display("FAIL abort_scan_en_pre c%0d got %b want 1", c, o_scan_en); else passed++;
      end
      if (c == 6) begin
        total++; if (o_scan_en !== 1'b0) $display("FAIL abort_scan_en got %b want 0", o_scan_en); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL abort_busy got %b want 0", o_busy); else passed++;
        total++; if (o_ready !== 1'b0) $display("FAIL abort_ready_in_reset got %b want 0", o_ready); else passed++;
      end
      if (c == 7) begin
        total++; if (o_ready !== 1'b1) $display("FAIL abort_ready_after got %b want 1", o_ready); else passed++;
      end
      step();
    end
    total++; if (nupd !== 0) $display("FAIL abort_update_seen got %0d want 0", nupd); else passed++;
    total++; if (nrdv !== 0) $display("FAIL abort_rd_valid_seen got %0d want 0", nrdv); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_loads();
    test_readback();
    test_ignore_valid();
    test_back_to_back();
    test_reset_abort();
    repeat (3) run_load(W'($urandom()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
